// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline registers.
// Tracks shadow copies of dst/regwrite/memread for EX, MEM and WB. From these
// it drives the stage enables, the IF/ID flush and ID/EX bubble, and the ALU
// forwarding selects. It resolves load-use stalls, taken-branch flushes and
// data-memory wait states, and flags a wait-state timeout.
// Optional feature macro: HAZARD_PERF_EN adds saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WLIM = WCNT_W'(WAIT_LIMIT);

  // Reject parameter values that make the counters meaningless.
  if (WAIT_LIMIT < 1) begin : g_bad_wait_limit
    $error("WAIT_LIMIT must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Shadow copies: _p0 = EX stage, _p1 = MEM stage, _p2 = WB stage
  logic [4:0] rs_p0, rt_p0, dst_p0;
  logic       regwrite_p0, memread_p0;
  logic [4:0] dst_p1;
  logic       regwrite_p1;
  logic [4:0] dst_p2;
  logic       regwrite_p2;

  logic [WCNT_W-1:0] wcnt_q;

  logic freeze;
  logic br_flush;
  logic lu_hit;
  logic lu_stall;
  logic ex_zero;

  // Wait-state counter increment, pinned at the timeout limit.
  function automatic logic [WCNT_W-1:0] sat_inc_wait(input logic [WCNT_W-1:0] v);
    return (v >= WLIM) ? WLIM : v + WCNT_W'(1);
  endfunction

  // Forwarding select: the younger EX/MEM result wins, $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       rw_mem,
                                         input logic [4:0] dst_mem,
                                         input logic       rw_wb,
                                         input logic [4:0] dst_wb);
    if (rw_mem && (dst_mem != 5'd0) && (dst_mem == src)) return 2'b10;
    if (rw_wb && (dst_wb != 5'd0) && (dst_wb == src))    return 2'b01;
    return 2'b00;
  endfunction

`ifdef HAZARD_PERF_EN
  // Performance counter increment, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction
`endif

  // Hazard classification: freeze outranks branch flush, which outranks load-use.
  always_comb begin
    freeze   = mem_req & ~mem_ready;
    br_flush = ex_branch_taken & ~freeze;
    lu_hit   = memread_p0 & regwrite_p0 & (dst_p0 != 5'd0) & id_valid &
               ((dst_p0 == id_rs) | (id_uses_rt & (dst_p0 == id_rt)));
    lu_stall = ~freeze & ~ex_branch_taken & lu_hit;
    ex_zero  = br_flush | lu_stall | ~id_valid;
  end

  // Pipeline-register controls; held at their pass-through values during reset.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    if (rst_n) begin
      if (freeze) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (br_flush) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Forwarding selects follow the shadows, so they stay stable while frozen.
  always_comb begin
    fwd_a = fwd_sel(rs_p0, regwrite_p1, dst_p1, regwrite_p2, dst_p2);
    fwd_b = fwd_sel(rt_p0, regwrite_p1, dst_p1, regwrite_p2, dst_p2);
  end

  // Memory wait FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (freeze)    state_d = ST_WAIT;
      ST_WAIT: if (mem_ready) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Memory wait FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Wait-state counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      mem_timeout <= 1'b0;
    end else if (freeze) begin
      wcnt_q <= sat_inc_wait(wcnt_q);
      if (sat_inc_wait(wcnt_q) == WLIM) mem_timeout <= 1'b1;
    end else begin
      wcnt_q <= '0;
    end
  end

  // Shadow advance: ID -> EX -> MEM -> WB on every non-frozen edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_p0       <= '0;
      rt_p0       <= '0;
      dst_p0      <= '0;
      regwrite_p0 <= 1'b0;
      memread_p0  <= 1'b0;
      dst_p1      <= '0;
      regwrite_p1 <= 1'b0;
      dst_p2      <= '0;
      regwrite_p2 <= 1'b0;
    end else if (!freeze) begin
      dst_p2      <= dst_p1;
      regwrite_p2 <= regwrite_p1;
      dst_p1      <= dst_p0;
      regwrite_p1 <= regwrite_p0;
      if (ex_zero) begin
        rs_p0       <= '0;
        rt_p0       <= '0;
        dst_p0      <= '0;
        regwrite_p0 <= 1'b0;
        memread_p0  <= 1'b0;
      end else begin
        rs_p0       <= id_rs;
        rt_p0       <= id_rt;
        dst_p0      <= id_dst;
        regwrite_p0 <= id_regwrite;
        memread_p0  <= id_memread;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counts of load-use stalls, branch flushes and freeze cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (lu_stall) stall_cnt <= sat_inc_cnt(stall_cnt);
      if (br_flush) flush_cnt <= sat_inc_cnt(flush_cnt);
      if (freeze)   wait_cnt  <= sat_inc_cnt(wait_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// a random phase, with a per-cycle scoreboard built from a reference model.
module tb_pipeline_hazard_ctrl;
  localparam int WAIT_LIMIT = 15;
  localparam int CNT_W      = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rt, id_regwrite, id_memread;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  // Packed output vector: pc,ifid_en,flush,idex_en,bubble,exmem,memwb,fwd_a,fwd_b,timeout
  typedef logic [11:0] outv_t;
  localparam outv_t IDLE_OUT = 12'b1101011_00_00_0;

  outv_t exp_q[$];
  int n_errors = 0;
  int n_checks = 0;

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB
  logic [4:0] m_rs[3], m_rt[3], m_dst[3];
  logic       m_rw[3], m_mr[3];
  int         m_cnt;
  logic       m_to;
  int         m_stall, m_flush, m_wait;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rs[i] = '0; m_rt[i] = '0; m_dst[i] = '0; m_rw[i] = 1'b0; m_mr[i] = 1'b0;
    end
    m_cnt = 0; m_to = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (m_rw[1] && m_dst[1] != 5'd0 && m_dst[1] == src) return 2'b10;
    if (m_rw[2] && m_dst[2] != 5'd0 && m_dst[2] == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic outv_t actual();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en,
            fwd_a, fwd_b, mem_timeout};
  endfunction

  // One clock cycle: drive after the edge, predict, compare at the negedge, advance model.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ut, input logic [4:0] dst, input logic rw,
                      input logic mr, input logic br, input logic mq, input logic mrdy);
    logic  fz, bf, lu, bub;
    outv_t e;
    @(posedge clk); #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = ut; id_dst = dst;
    id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
    mem_req = mq; mem_ready = mrdy;
    fz  = mq & ~mrdy;
    bf  = br & ~fz;
    lu  = ~fz & ~br & m_mr[0] & m_rw[0] & (m_dst[0] != 5'd0) & v &
          ((m_dst[0] == rs) | (ut & (m_dst[0] == rt)));
    bub = bf | lu;
    e = {~fz & ~lu, ~fz & ~lu, bf, ~fz, bub, ~fz, ~fz,
         exp_fwd(m_rs[0]), exp_fwd(m_rt[0]), m_to};
    exp_q.push_back(e);
    @(negedge clk);
    check("cycle_outputs", actual(), exp_q.pop_front());
    if (!fz) begin
      for (int i = 2; i > 0; i--) begin
        m_rs[i] = m_rs[i-1]; m_rt[i] = m_rt[i-1]; m_dst[i] = m_dst[i-1];
        m_rw[i] = m_rw[i-1]; m_mr[i] = m_mr[i-1];
      end
      if (bub | ~v) begin
        m_rs[0] = '0; m_rt[0] = '0; m_dst[0] = '0; m_rw[0] = 1'b0; m_mr[0] = 1'b0;
      end else begin
        m_rs[0] = rs; m_rt[0] = rt; m_dst[0] = dst; m_rw[0] = rw; m_mr[0] = mr;
      end
    end
    m_cnt = fz ? ((m_cnt + 1 > WAIT_LIMIT) ? WAIT_LIMIT : m_cnt + 1) : 0;
    if (fz && m_cnt == WAIT_LIMIT) m_to = 1'b1;
    m_stall += int'(lu); m_flush += int'(bf); m_wait += int'(fz);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic freeze_cyc();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset with hostile inputs: enables must still be 1, controls 0
    rst_n = 1'b0;
    id_valid = 1; id_rs = 1; id_rt = 1; id_uses_rt = 1; id_dst = 1;
    id_regwrite = 1; id_memread = 1; ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
    #12;
    check("reset_outputs", actual(), IDLE_OUT);
    id_valid = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 1;
    #4 rst_n = 1'b1;

    // Load-use: lw $8 then add using $8
    step(1, 0, 0, 0, 8, 1, 1, 0, 0, 1);
    step(1, 8, 9, 1, 10, 1, 0, 0, 0, 1);
    check("lu_pc_en", pc_en, 0);
    check("lu_ifid_en", ifid_en, 0);
    check("lu_bubble", idex_bubble, 1);
    step(1, 8, 9, 1, 10, 1, 0, 0, 0, 1);
    check("lu_one_cycle", {pc_en, idex_bubble}, 2'b10);
    nop();
    check("lu_fwd_a_wb", fwd_a, 2'b01);
    check("lu_fwd_b_none", fwd_b, 2'b00);

    // Forwarding priority on back-to-back writes to $5
    step(1, 1, 2, 1, 5, 1, 0, 0, 0, 1);
    step(1, 3, 4, 1, 5, 1, 0, 0, 0, 1);
    step(1, 5, 5, 1, 6, 1, 0, 0, 0, 1);
    nop();
    check("fwd_a_exmem", fwd_a, 2'b10);
    check("fwd_b_exmem", fwd_b, 2'b10);
    step(1, 1, 2, 1, 0, 1, 0, 0, 0, 1);
    step(1, 3, 4, 1, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 6, 1, 0, 0, 0, 1);
    nop();
    check("fwd_r0_a", fwd_a, 2'b00);
    check("fwd_r0_b", fwd_b, 2'b00);

    // Branch in the same cycle as a load-use condition
    step(1, 0, 0, 0, 7, 1, 1, 0, 0, 1);
    step(1, 7, 0, 0, 9, 1, 0, 1, 0, 1);
    check("br_flush", {pc_en, ifid_flush, idex_bubble}, 3'b111);
    nop();
    check("br_no_stall", {pc_en, ifid_en}, 2'b11);

    // Memory wait with a live forward in flight
    step(1, 0, 0, 0, 3, 1, 0, 0, 0, 1);
    step(1, 3, 0, 0, 4, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      freeze_cyc();
      check("wait_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b0);
      check("wait_fwd_hold", fwd_a, 2'b10);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("wait_release", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    check("wait_fwd_after", fwd_a, 2'b10);

    // Timeout after WAIT_LIMIT consecutive freeze cycles
    for (int i = 0; i < WAIT_LIMIT; i++) freeze_cyc();
    check("timeout_not_yet", mem_timeout, 0);
    nop();
    check("timeout_set", mem_timeout, 1);
    nop(); nop();
    check("timeout_sticky", mem_timeout, 1);

    // Asynchronous reset in the middle of a wait
    freeze_cyc(); freeze_cyc();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", actual(), IDLE_OUT);
    model_reset();
    mem_req = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Counting scenario: two load-use stalls, one flush, four wait cycles
    step(1, 0, 0, 0, 2, 1, 1, 0, 0, 1);
    step(1, 2, 0, 0, 3, 1, 0, 0, 0, 1);
    step(1, 2, 0, 0, 3, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 4, 1, 1, 0, 0, 1);
    step(1, 1, 4, 1, 5, 1, 0, 0, 0, 1);
    step(1, 1, 4, 1, 5, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) freeze_cyc();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("count_stalls_model", m_stall, 2);
`ifdef HAZARD_PERF_EN
    check("perf_stall_cnt", stall_cnt, 2);
    check("perf_flush_cnt", flush_cnt, 1);
    check("perf_wait_cnt", wait_cnt, 4);
`endif

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 250; i++) begin
      logic mq;
      mq = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), mq,
           mq ? 1'($urandom_range(0, 1)) : 1'b1);
    end
`ifdef HAZARD_PERF_EN
    check("perf_stall_rand", stall_cnt, m_stall);
    check("perf_flush_rand", flush_cnt, m_flush);
    check("perf_wait_rand", wait_cnt, m_wait);
`endif
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Keeps its own shadow copies of destination register, regwrite and memread for the EX, MEM and WB stages.
- From these it drives per-stage enables, bubble/flush controls and ALU forwarding selects.
- Resolves load-use hazards, taken-branch flushes and data-memory wait states, with a wait-state timeout.

Parameters:
- WAIT_LIMIT, 15: max consecutive cycles of mem_ready low before mem_timeout asserts.
- CNT_W, 16: width of performance counters (optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- id_uses_rt  in  1  ID instruction reads rt as an operand
- id_dst  in  5  ID destination after RegDst mux
- id_regwrite  in  1  ID regwrite control
- id_memread  in  1  ID memread control
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_req  in  1  MEM stage is issuing a load or store
- mem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID load zero (nop)
- idex_en  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX load zero controls
- exmem_en  out  1  EX/MEM load enable
- memwb_en  out  1  MEM/WB load enable
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  EX operand B select, same encoding
- mem_timeout  out  1  sticky wait-state timeout flag

Behaviour:
- Reset (rst_n low, async):
  - All shadow stage copies are cleared (regwrite=0, memread=0, dst=0, rs/rt=0).
  - FSM goes to RUN, wait counter = 0, mem_timeout = 0.
  - Outputs during reset: all enables 1, flush/bubble 0, fwd 00.
- FSM states:
  - RUN: mem_req & !mem_ready -> WAIT.
  - WAIT: mem_ready -> RUN.
  - Reset mid-WAIT returns to RUN immediately.
- freeze = mem_req & !mem_ready, evaluated combinationally in either state.
  - pc_en, ifid_en, idex_en, exmem_en and memwb_en are all 0.
  - Flush and bubble are 0.
  - Shadow copies hold.
- Wait counter:
  - Increments each freeze cycle, saturating at WAIT_LIMIT.
  - Clears on any non-freeze cycle.
  - mem_timeout sets when the counter reaches WAIT_LIMIT and stays set until reset.
- Priority: freeze > branch flush > load-use stall.
- Branch flush (ex_branch_taken & !freeze), single cycle:
  - pc_en=1, ifid_flush=1, idex_bubble=1.
  - Load-use detection is ignored this cycle.
- Load-use hazard (lu), when !freeze & !ex_branch_taken:
  - Condition: ex_memread & ex_regwrite & ex_dst!=0 & id_valid & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).
  - Response: pc_en=0, ifid_en=0, idex_bubble=1.
  - Lasts exactly one cycle, because the bubble clears ex_memread.
- Shadow advance, on each non-freeze edge:
  - wb <= mem; mem <= ex.
  - ex <= zeros if (idex_bubble | !id_valid), else the ID fields.
- Forwarding, evaluated for ex_rs -> fwd_a and ex_rt -> fwd_b:
  - 10 if mem_regwrite & mem_dst!=0 & mem_dst==src.
  - Else 01 if wb_regwrite & wb_dst!=0 & wb_dst==src.
  - Else 00.
  - EX/MEM takes precedence over MEM/WB.
  - Register 0 never forwards.
  - fwd is valid during freeze and reflects the held shadows.
- All hazard outputs are combinational from the shadows and current inputs; there is no output latency beyond that.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds outputs:
  - stall_cnt [CNT_W-1:0]: counts load-use stall cycles.
  - flush_cnt [CNT_W-1:0]: counts branch flushes.
  - wait_cnt [CNT_W-1:0]: counts freeze cycles.
- Counters saturate at all-ones and reset to 0 asynchronously.
- When undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Load-use stall: lw $8 (id_memread=1, id_dst=8), then add with id_rs=8 -> next cycle pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle; two cycles later fwd_a=01.
- Forwarding priority: back-to-back writes to $5 (ALU, ALU), then use of rs=5 -> fwd_a=10; with rt=5, uses_rt=1 -> fwd_b=10; writes to $0 -> fwd stays 00.
- Branch beats load-use: ex_branch_taken=1 in the same cycle a load-use condition exists -> ifid_flush=1, idex_bubble=1, pc_en=1, no stall cycle follows.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles -> all enables 0 for 3 cycles, shadows unchanged, fwd stable; mem_ready=1 -> enables return to 1, state RUN.
- Timeout: WAIT_LIMIT=15, mem_ready held low for 15 cycles -> mem_timeout=1 and stays 1 after mem_ready rises; assert rst_n=0 mid-wait -> mem_timeout=0, state RUN, enables=1 asynchronously.
- HAZARD_PERF_EN defined: 2 load-use stalls, 1 flush, 4 wait cycles -> stall_cnt=2, flush_cnt=1, wait_cnt=4.
